phase_seq_gen: RTL

//   Parametrised multi-phase output sequencer: steps through PHASES table entries, each held for a

---
 rtl/phase_seq_gen_if.sv | 67 ++++++
 rtl/phase_seq_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/phase_seq_gen_if.sv
// ---------------------------------------------------------------------------
// phase_seq_gen_if
//   Bundles the control, table-configuration and output signals of
//   phase_seq_gen.  clk and rst_n stay plain ports on the sequencer.
//
//   Optional feature macro: PHASE_SEQ_PAUSE_EN (adds the pause signal).
//
//   Signals (direction seen from the sequencer, i.e. the slave modport):
//     en         in   tick strobe
//     start      in   begin run at phase 0 (acted on in IDLE only)
//     stop       in   abort run, return to IDLE
//     loop_mode  in   1: wrap last phase to phase 0, 0: one-shot
//     cfg_we     in   table write strobe
//     cfg_addr   in   table entry index          [AW-1:0]
//     cfg_dwell  in   dwell ticks for entry      [CW-1:0]
//     cfg_d0     in   dout0 code for entry       [DW-1:0]
//     cfg_d1     in   dout1 code for entry       [DW-1:0]
//     pause      in   hold run (PHASE_SEQ_PAUSE_EN only)
//     busy       out  high while not IDLE
//     phase      out  current phase index        [AW-1:0]
//     dout0      out  output code 0              [DW-1:0]
//     dout1      out  output code 1              [DW-1:0]
//     done       out  one-cycle pulse on one-shot completion
// ---------------------------------------------------------------------------
interface phase_seq_gen_if #(
  parameter int PHASES = 5,
  parameter int DW     = 2,
  parameter int CW     = 3
);
  localparam int AW = (PHASES > 1) ? $clog2(PHASES) : 1;

  logic          en;
  logic          start;
  logic          stop;
  logic          loop_mode;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_dwell;
  logic [DW-1:0] cfg_d0;
  logic [DW-1:0] cfg_d1;
`ifdef PHASE_SEQ_PAUSE_EN
  logic          pause;
`endif
  logic          busy;
  logic [AW-1:0] phase;
  logic [DW-1:0] dout0;
  logic [DW-1:0] dout1;
  logic          done;

  modport master (
`ifdef PHASE_SEQ_PAUSE_EN
    output pause,
`endif
    output en, start, stop, loop_mode,
    output cfg_we, cfg_addr, cfg_dwell, cfg_d0, cfg_d1,
    input  busy, phase, dout0, dout1, done
  );

  modport slave (
`ifdef PHASE_SEQ_PAUSE_EN
    input  pause,
`endif
    input  en, start, stop, loop_mode,
    input  cfg_we, cfg_addr, cfg_dwell, cfg_d0, cfg_d1,
    output busy, phase, dout0, dout1, done
  );
endinterface

// File: rtl/phase_seq_gen.sv
// ---------------------------------------------------------------------------
// phase_seq_gen
//   Multi-phase output sequencer.  Steps through PHASES table entries, each
//   held for a programmable number of en ticks, and drives two registered
//   DW-bit codes per phase.  One-shot or looping runs, start/stop control,
//   one-cycle done pulse at the end of a one-shot run.
//
//   Optional feature macro: PHASE_SEQ_PAUSE_EN
//     defined   : bus.pause exists; RUN & pause -> PAUSE, everything frozen
//     undefined : no pause input, RUN never freezes
//
//   Ports:
//     clk    in  system clock
//     rst_n  in  asynchronous active-low reset (also reinitialises table)
//     bus    phase_seq_gen_if.slave: en/start/stop/loop_mode, cfg_* table
//            write port, busy/phase/dout0/dout1/done outputs
// ---------------------------------------------------------------------------
module phase_seq_gen #(
  parameter int PHASES = 5,
  parameter int DW     = 2,
  parameter int CW     = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  phase_seq_gen_if.slave bus
);

  localparam int AW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [AW-1:0] LAST_PHASE = AW'(PHASES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Phase table
  logic [CW-1:0] dwell_tbl [PHASES];
  logic [DW-1:0] d0_tbl    [PHASES];
  logic [DW-1:0] d1_tbl    [PHASES];

  // Sequencer state
  state_t        state_q,  state_d;
  logic [AW-1:0] phase_q,  phase_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [DW-1:0] dout0_q,  dout0_d;
  logic [DW-1:0] dout1_q,  dout1_d;
  logic          done_q,   done_d;

  logic          tbl_wr;
  logic [CW-1:0] dwell_cur;
  logic [CW-1:0] last_cnt;
  logic          phase_end;
  logic          pause_req;

`ifdef PHASE_SEQ_PAUSE_EN
  assign pause_req = bus.pause;
`else
  assign pause_req = 1'b0;
`endif

  // ---- table write port --------------------------------------------------
  // Writes are accepted only while idle so a running pattern never changes
  // underneath itself; out-of-range addresses are dropped.
  assign tbl_wr = bus.cfg_we && (state_q == S_IDLE) &&
                  (int'(bus.cfg_addr) < PHASES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHASES; i++) begin
        dwell_tbl[i] <= CW'(1);
        d0_tbl[i]    <= '0;
        d1_tbl[i]    <= '0;
      end
    end else if (tbl_wr) begin
      dwell_tbl[bus.cfg_addr] <= bus.cfg_dwell;
      d0_tbl[bus.cfg_addr]    <= bus.cfg_d0;
      d1_tbl[bus.cfg_addr]    <= bus.cfg_d1;
    end
  end

  // ---- dwell terminal count ----------------------------------------------
  // A stored dwell of 0 behaves as 1, so the terminal count is 0 in both
  // cases and the counter can never run past dwell-1 (no wrap).
  assign dwell_cur = dwell_tbl[phase_q];
  assign last_cnt  = (dwell_cur == '0) ? '0 : (dwell_cur - CW'(1));
  assign phase_end = bus.en && (cnt_q == last_cnt);

  // ---- next-state / next-output logic ------------------------------------
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start together with stop keeps the sequencer idle
        if (bus.start && !bus.stop) begin
          state_d = S_RUN;
          phase_d = '0;
          cnt_d   = '0;
        end
      end

      S_RUN: begin
        // stop has priority over pause and over any phase end
        if (bus.stop) begin
          state_d = S_IDLE;
          phase_d = '0;
          cnt_d   = '0;
        end else if (pause_req) begin
          state_d = S_PAUSE;
        end else if (phase_end) begin
          cnt_d = '0;
          if (phase_q != LAST_PHASE) begin
            phase_d = phase_q + AW'(1);
          end else if (bus.loop_mode) begin
            phase_d = '0;
          end else begin
            state_d = S_IDLE;
            phase_d = '0;
            done_d  = 1'b1;
          end
        end else if (bus.en) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_PAUSE: begin
        // counter and phase are frozen; ticks are ignored here
        if (bus.stop) begin
          state_d = S_IDLE;
          phase_d = '0;
          cnt_d   = '0;
        end else if (!pause_req) begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
        phase_d = '0;
        cnt_d   = '0;
      end
    endcase

    // Codes follow the phase on the same edge and are forced to zero in IDLE.
    if (state_d == S_IDLE) begin
      dout0_d = '0;
      dout1_d = '0;
    end else begin
      dout0_d = d0_tbl[phase_d];
      dout1_d = d1_tbl[phase_d];
    end
  end

  // ---- state / output registers ------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      dout0_q <= '0;
      dout1_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.phase = phase_q;
  assign bus.dout0 = dout0_q;
  assign bus.dout1 = dout1_q;
  assign bus.done  = done_q;

endmodule
